// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding
// and the RV32I load funct3 codes recognised by the load aligner.
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handshake plus the memory load response.
// master: execute/memory side; slave: the writeback stage.
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_wen;
  logic            ex_is_load;
  logic [2:0]      ex_funct3;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output ex_valid, ex_wen, ex_is_load, ex_funct3, ex_rd, ex_result,
    output mem_rvalid, mem_rdata,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_wen, ex_is_load, ex_funct3, ex_rd, ex_result,
    input  mem_rvalid, mem_rdata,
    output ex_ready
  );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by
// addr_lo out of the 32-bit memory word and sign- or zero-extends it.
// err flags a misaligned access or an unsupported funct3.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
  assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Select and extend according to the load type
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'(byte_s);
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        data = XLEN'(half_s);
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, half_s};
        err  = addr_lo[0];
      end
      F3_LW: begin
        data = rdata;
        err  = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage and sole writer of the register bank.
// Non-loads write one cycle after acceptance; loads park in WAIT_MEM until
// mem_rvalid, then write the aligned data one cycle later. Upstream is
// stalled (ex_ready=0) while a load is outstanding.
// Optional feature: define WB_RETIRE_CNT_EN to add the instret counter port.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  writeback_stage_if.slave bus,
  output logic             we,
  output logic [4:0]       ain,
  output logic [XLEN-1:0]  din,
  output logic             load_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  wb_state_e       state;
  logic [4:0]      p_rd;
  logic            p_wen;
  logic [2:0]      p_funct3;
  logic [1:0]      p_addr_lo;

  logic            accept;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [XLEN-1:0] al_data;
  logic            al_err;

  assign bus.ex_ready = (state == IDLE);
  assign accept       = bus.ex_valid && (state == IDLE);

  // One aligner serves both phases: in IDLE it screens the incoming load
  // for misalignment, in WAIT_MEM it extracts data for the latched load.
  assign al_funct3  = (state == WAIT_MEM) ? p_funct3  : bus.ex_funct3;
  assign al_addr_lo = (state == WAIT_MEM) ? p_addr_lo : bus.ex_result[1:0];

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (al_funct3),
    .addr_lo (al_addr_lo),
    .rdata   (bus.mem_rdata),
    .data    (al_data),
    .err     (al_err)
  );

  // FSM, pending-load latch and registered register-bank write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      we        <= 1'b0;
      ain       <= '0;
      din       <= '0;
      load_err  <= 1'b0;
      p_rd      <= '0;
      p_wen     <= 1'b0;
      p_funct3  <= '0;
      p_addr_lo <= '0;
    end else begin
      we       <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.ex_is_load) begin
              if (al_err) begin
                load_err <= 1'b1;
              end else begin
                state     <= WAIT_MEM;
                p_rd      <= bus.ex_rd;
                p_wen     <= bus.ex_wen;
                p_funct3  <= bus.ex_funct3;
                p_addr_lo <= bus.ex_result[1:0];
              end
            end else if (bus.ex_wen && (bus.ex_rd != 5'd0)) begin
              we  <= 1'b1;
              ain <= bus.ex_rd;
              din <= bus.ex_result;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
            if (p_wen && (p_rd != 5'd0)) begin
              we  <= 1'b1;
              ain <= p_rd;
              din <= al_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire;

  assign retire = (accept && (!bus.ex_is_load || al_err)) ||
                  ((state == WAIT_MEM) && bus.mem_rvalid);

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import wb_pkg::*;

  logic clock;
  logic reset_n;
  logic we;
  logic [4:0] ain;
  logic [31:0] din;
  logic load_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  writeback_stage_if #(.XLEN(32)) bus ();

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .we       (we),
    .ain      (ain),
    .din      (din),
    .load_err (load_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret  (instret)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_load;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wen;
    logic [31:0] rdata;
    int          wait_cyc;
    logic        exp_we;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [4:0]  ain;
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write or error pulse must match the next expected record
  always @(posedge clock) begin
    #1;
    if (we === 1'b1 || load_err === 1'b1) begin
      if (we === 1'b1) wr_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output we=%0b ain=%0d din=%0h load_err=%0b required none",
                 we, ain, din, load_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_we", {63'd0, we}, {63'd0, ~e.err});
        chk("sb_load_err", {63'd0, load_err}, {63'd0, e.err});
        if (!e.err) begin
          chk("sb_ain", {59'd0, ain}, {59'd0, e.ain});
          chk("sb_din", {32'd0, din}, {32'd0, e.din});
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.ex_valid   = 1'b0;
    bus.ex_wen     = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_funct3  = 3'b000;
    bus.ex_rd      = 5'd0;
    bus.ex_result  = 32'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clock); #2;
    bus.ex_valid   = 1'b1;
    bus.ex_is_load = v.is_load;
    bus.ex_funct3  = v.f3;
    bus.ex_rd      = v.rd;
    bus.ex_result  = v.res;
    bus.ex_wen     = v.wen;
    if (v.exp_we || v.exp_err) sb.push_back('{v.rd, v.exp_din, v.exp_err});
    @(posedge clock); #2;
    bus.ex_valid = 1'b0;
    if (v.is_load && !v.exp_err) begin
      for (int i = 0; i < v.wait_cyc; i++) begin
        chk($sformatf("vec%0d_stall", idx), {63'd0, bus.ex_ready}, 64'd0);
        @(posedge clock); #2;
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.rdata;
      @(posedge clock); #2;
      bus.mem_rvalid = 1'b0;
    end
    chk($sformatf("vec%0d_ready", idx), {63'd0, bus.ex_ready}, 64'd1);
    @(posedge clock); #2;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    //                load f3      rd  res           wen rdata         wt  we  din           err
    tbl[0]  = '{1'b0, 3'b000, 5,  32'hDEADBEEF, 1, 32'h0,         0,  1, 32'hDEADBEEF, 0};
    tbl[1]  = '{1'b1, F3_LB,  6,  32'h00001003, 1, 32'h80FF1234,  3,  1, 32'hFFFFFF80, 0};
    tbl[2]  = '{1'b1, F3_LHU, 7,  32'h00002002, 1, 32'hABCD0000,  1,  1, 32'h0000ABCD, 0};
    tbl[3]  = '{1'b1, F3_LH,  8,  32'h00000001, 1, 32'h0,         0,  0, 32'h0,        1};
    tbl[4]  = '{1'b1, F3_LW,  9,  32'h00000100, 1, 32'h12345678,  1,  1, 32'h12345678, 0};
    tbl[5]  = '{1'b1, F3_LBU, 10, 32'h00000001, 1, 32'h0000A500,  2,  1, 32'h000000A5, 0};
    tbl[6]  = '{1'b1, F3_LH,  11, 32'h00000002, 1, 32'h80010000,  1,  1, 32'hFFFF8001, 0};
    tbl[7]  = '{1'b1, F3_LW,  12, 32'h00000002, 1, 32'h0,         0,  0, 32'h0,        1};
    tbl[8]  = '{1'b1, 3'b011, 13, 32'h00000000, 1, 32'h0,         0,  0, 32'h0,        1};
    tbl[9]  = '{1'b0, 3'b000, 0,  32'h11111111, 1, 32'h0,         0,  0, 32'h0,        0};
    tbl[10] = '{1'b1, F3_LW,  0,  32'h00000000, 1, 32'hCAFEF00D,  1,  0, 32'h0,        0};
    tbl[11] = '{1'b0, 3'b000, 7,  32'h22222222, 0, 32'h0,         0,  0, 32'h0,        0};
    tbl[12] = '{1'b1, F3_LB,  14, 32'h00000000, 1, 32'h0000007F,  0,  1, 32'h0000007F, 0};
    tbl[13] = '{1'b1, F3_LHU, 15, 32'h00000000, 1, 32'h1234FFFF,  2,  1, 32'h0000FFFF, 0};

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_ain", {59'd0, ain}, 64'd0);
    chk("rst_din", {32'd0, din}, 64'd0);
    chk("rst_load_err", {63'd0, load_err}, 64'd0);
    chk("rst_ready", {63'd0, bus.ex_ready}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_instret", instret, 64'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // Response on the accept cycle is ignored; the load keeps waiting
    @(posedge clock); #2;
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_funct3 = F3_LW;
    bus.ex_rd = 5'd20; bus.ex_result = 32'h40; bus.ex_wen = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
    @(posedge clock); #2;
    bus.ex_valid = 1'b0; bus.mem_rvalid = 1'b0;
    @(posedge clock); #2;
    chk("acc_rvalid_still_wait", {63'd0, bus.ex_ready}, 64'd0);
    sb.push_back('{5'd20, 32'h600DF00D, 1'b0});
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600DF00D;
    @(posedge clock); #2;
    bus.mem_rvalid = 1'b0;
    @(posedge clock); #2;

    // Stray response while idle: no write, no error
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clock); #2;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("idle_rvalid_ready", {63'd0, bus.ex_ready}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("instret_after_table", instret, 64'd15);
`endif
    chk("sb_drained_1", sb.size(), 64'd0);

    // Ten back-to-back ALU ops after a fresh reset
    do_reset();
    wr_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #2;
      bus.ex_valid = 1'b1; bus.ex_is_load = 1'b0; bus.ex_wen = 1'b1;
      bus.ex_rd = 5'(i); bus.ex_result = 32'h1000 + i;
      sb.push_back('{5'(i), 32'h1000 + i, 1'b0});
    end
    @(posedge clock); #2;
    bus.ex_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("b2b_writes", wr_cnt, 64'd10);
`ifdef WB_RETIRE_CNT_EN
    chk("b2b_instret", instret, 64'd10);
`endif
    chk("sb_drained_2", sb.size(), 64'd0);

    // Reset while a load is outstanding discards it
    @(posedge clock); #2;
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_funct3 = F3_LW;
    bus.ex_rd = 5'd3; bus.ex_result = 32'h0; bus.ex_wen = 1'b1;
    @(posedge clock); #2;
    bus.ex_valid = 1'b0;
    @(posedge clock); #2;
    chk("pre_rst_wait", {63'd0, bus.ex_ready}, 64'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ready", {63'd0, bus.ex_ready}, 64'd1);
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #2;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77777777;
    @(posedge clock); #2;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("post_rst_we", {63'd0, we}, 64'd0);
    chk("post_rst_ready", {63'd0, bus.ex_ready}, 64'd1);
    chk("sb_drained_3", sb.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
